// File: rtl/hazard_fetch_stage.sv
// hazard_fetch_stage: PC/instruction-register fetch stage that stalls with NOP bubbles on register RAW hazards
//   clk             in   clock, all state on rising edge
//   rst_n           in   asynchronous active-low reset
//   i_en            in   run enable; when low a NOP slot is issued and pc holds
//   i_prog_last     in   word address of the last program instruction
//   o_imem_addr     out  instruction memory read address (= pc)
//   i_imem_data     in   instruction word at o_imem_addr, same cycle
//   o_instruction   out  registered instruction driving Control
//   o_instr_valid   out  slot came from memory rather than an internal bubble
//   o_pc            out  current fetch address
//   o_done          out  last program word has been issued
//   o_bubble_cnt    out  saturating count of hazard bubbles injected
module hazard_fetch_stage #(
   parameter int          ADDR_W       = 8,
   parameter int          HAZARD_DEPTH = 3,
   parameter logic [31:0] NOP_WORD     = 32'h1000_0280
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_prog_last,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [31:0]       i_imem_data,
   output logic [31:0]       o_instruction,
   output logic              o_instr_valid,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_done,
   output logic [15:0]       o_bubble_cnt
);
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_instr;
   logic              r_valid;
   logic              r_done;
   logic [15:0]       r_bubbles;
   logic              r_sb_v [HAZARD_DEPTH];
   logic [4:0]        r_sb_r [HAZARD_DEPTH];
   logic [5:0]        w_op;
   logic [4:0]        w_rs;
   logic [4:0]        w_rt;
   logic              w_is_r;
   logic              w_is_lw;
   logic              w_is_sw;
   logic              w_use_a;
   logic              w_use_b;
   logic              w_has_dest;
   logic [4:0]        w_dest;
   logic              w_hazard;
   logic              w_issue;
   logic              w_stall;
   assign w_op       = i_imem_data[31:26];
   assign w_rs       = i_imem_data[25:21];
   assign w_rt       = i_imem_data[20:16];
   // funct 0 inside group R is the NOP encoding: no operands at all
   assign w_is_r     = (w_op == 6'b000100) && (i_imem_data[5:0] != 6'd0);
   assign w_is_lw    = (w_op == 6'b000101);
   assign w_is_sw    = (w_op == 6'b000110);
   assign w_use_a    = w_is_r || w_is_sw;
   assign w_use_b    = w_is_r || w_is_lw || w_is_sw;
   assign w_has_dest = w_is_r || w_is_lw;
   assign w_dest     = w_is_lw ? w_rs : i_imem_data[15:11];
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < HAZARD_DEPTH; i++)
         if (r_sb_v[i] && ((w_use_a && r_sb_r[i] == w_rs) || (w_use_b && r_sb_r[i] == w_rt)))
            w_hazard = 1'b1;
   end
   // done and disable take priority, so only a genuine hazard counts as a bubble
   assign w_issue = !r_done && i_en && !w_hazard;
   assign w_stall = !r_done && i_en && w_hazard;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= '0;
         r_instr   <= NOP_WORD;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_bubbles <= '0;
         for (int i = 0; i < HAZARD_DEPTH; i++) begin
            r_sb_v[i] <= 1'b0;
            r_sb_r[i] <= '0;
         end
      end else begin
         r_instr <= w_issue ? i_imem_data : NOP_WORD;
         r_valid <= w_issue;
         if (w_issue && r_pc == i_prog_last)
            r_done <= 1'b1;
         else if (w_issue)
            r_pc <= r_pc + ADDR_W'(1);
         if (w_stall && r_bubbles != 16'hFFFF)
            r_bubbles <= r_bubbles + 16'd1;
         // the scoreboard ages every cycle; non-issuing slots shift in an empty entry
         r_sb_v[0] <= w_issue && w_has_dest;
         r_sb_r[0] <= w_dest;
         for (int i = 1; i < HAZARD_DEPTH; i++) begin
            r_sb_v[i] <= r_sb_v[i-1];
            r_sb_r[i] <= r_sb_r[i-1];
         end
      end
   end
   assign o_imem_addr   = r_pc;
   assign o_pc          = r_pc;
   assign o_instruction = r_instr;
   assign o_instr_valid = r_valid;
   assign o_done        = r_done;
   assign o_bubble_cnt  = r_bubbles;
endmodule

// File: tb/tb_hazard_fetch_stage.sv
// tb_hazard_fetch_stage: directed self-checking bench for hazard_fetch_stage (depth 3 and depth 1 instances)
//   no ports; drives clk/rst_n/en/prog_last and models instruction memory
module tb_hazard_fetch_stage;
   localparam logic [31:0] NOP = 32'h1000_0280;
   localparam logic [31:0] LW0 = 32'h1400_0000;
   localparam logic [31:0] LW1 = 32'h1421_0000;
   localparam logic [31:0] LW2 = 32'h1442_0000;
   localparam logic [31:0] LW3 = 32'h1463_0000;
   localparam logic [31:0] LW4 = 32'h1484_0000;
   localparam logic [31:0] SUB = 32'h1085_32A2;
   localparam logic [31:0] MUL = 32'h1001_2290;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [7:0]  prog_last = '0;
   logic [31:0] mem [256];
   logic [7:0]  a0, a1, pc0, pc1;
   logic [31:0] ins0, ins1;
   logic        v0, v1, d0, d1;
   logic [15:0] bc0, bc1;
   int          n_chk = 0;
   int          n_err = 0;
   always #5 clk = ~clk;
   hazard_fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_prog_last(prog_last),
      .o_imem_addr(a0), .i_imem_data(mem[a0]), .o_instruction(ins0),
      .o_instr_valid(v0), .o_pc(pc0), .o_done(d0), .o_bubble_cnt(bc0));
   hazard_fetch_stage #(.HAZARD_DEPTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_prog_last(prog_last),
      .o_imem_addr(a1), .i_imem_data(mem[a1]), .o_instruction(ins1),
      .o_instr_valid(v1), .o_pc(pc1), .o_done(d1), .o_bubble_cnt(bc1));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic restart(input logic [7:0] last);
      @(negedge clk);
      rst_n = 1'b0;
      en = 1'b1;
      prog_last = last;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
   endtask
   task automatic release_rst();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      // independent lw stream, register 0 included
      restart(8'd3);
      mem[0] = LW0; mem[1] = LW1; mem[2] = LW2; mem[3] = LW3;
      release_rst();
      check("rst_addr", 32'(a0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("ind_ins%0d", i), ins0, mem[i]);
         check($sformatf("ind_v%0d", i), 32'(v0), 32'd1);
      end
      check("ind_done", 32'(d0), 32'd1);
      check("ind_bub", 32'(bc0), 32'd0);
      check("ind_pc", 32'(pc0), 32'd3);
      step();
      check("post_done_ins", ins0, NOP);
      check("post_done_v", 32'(v0), 32'd0);
      // asynchronous reset between edges
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ins", ins0, NOP);
      check("arst_pc", 32'(pc0), 32'd0);
      check("arst_v", 32'(v0), 32'd0);
      check("arst_done", 32'(d0), 32'd0);
      check("arst_bub", 32'(bc0), 32'd0);
      // load-use: three bubbles then sub
      restart(8'd1);
      mem[0] = LW4; mem[1] = SUB;
      release_rst();
      step();
      check("lu_lw", ins0, LW4);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("lu_bins%0d", i), ins0, NOP);
         check($sformatf("lu_bv%0d", i), 32'(v0), 32'd0);
         check($sformatf("lu_bpc%0d", i), 32'(pc0), 32'd1);
      end
      step();
      check("lu_sub", ins0, SUB);
      check("lu_subv", 32'(v0), 32'd1);
      check("lu_bub", 32'(bc0), 32'd3);
      check("lu_done", 32'(d0), 32'd1);
      // program NOPs cover the distance, no injected bubbles
      restart(8'd4);
      mem[0] = LW4; mem[1] = NOP; mem[2] = NOP; mem[3] = NOP; mem[4] = SUB;
      release_rst();
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("pn_ins%0d", i), ins0, mem[i]);
         check($sformatf("pn_v%0d", i), 32'(v0), 32'd1);
      end
      check("pn_bub", 32'(bc0), 32'd0);
      // dual dependency on depth 3 and depth 1
      restart(8'd2);
      mem[0] = LW0; mem[1] = LW1; mem[2] = MUL;
      release_rst();
      step();
      step();
      check("dd_lw1", ins0, LW1);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("dd_bv%0d", i), 32'(v0), 32'd0);
         if (i == 0) check("dd1_bv", 32'(v1), 32'd0);
         if (i == 1) check("dd1_mul", ins1, MUL);
      end
      step();
      check("dd_mul", ins0, MUL);
      check("dd_mulv", 32'(v0), 32'd1);
      check("dd_bub", 32'(bc0), 32'd3);
      check("dd1_bub", 32'(bc1), 32'd1);
      // enable low freezes pc and issues NOP slots
      restart(8'd2);
      mem[0] = LW0; mem[1] = LW1; mem[2] = LW2;
      release_rst();
      step();
      check("en_lw0", ins0, LW0);
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("en_ins%0d", i), ins0, NOP);
         check($sformatf("en_v%0d", i), 32'(v0), 32'd0);
         check($sformatf("en_pc%0d", i), 32'(pc0), 32'd1);
      end
      en = 1'b1;
      step();
      check("en_lw1", ins0, LW1);
      step();
      check("en_lw2", ins0, LW2);
      check("en_done", 32'(d0), 32'd1);
      check("en_pc_hold", 32'(pc0), 32'd2);
      step();
      check("en_tail_ins", ins0, NOP);
      check("en_tail_v", 32'(v0), 32'd0);
      check("en_tail_pc", 32'(pc0), 32'd2);
      check("en_bub", 32'(bc0), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
